alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised successor to the single-cycle datapath ALU. It keeps the existing opcodes, adds OR and the two shifts, and adds iterative unsigned multiply. Divide and remainder are optional. Operands are accepted through a valid/ready handshake and each result is held until the consumer takes it. It sits between the register-read stage and writeback and lets the core stall on long operations.

## Interface
- WIDTH, default `WORD: operand and result width, must be ≥ 4.
- OP_WIDTH, default `OP_WIDTH: opcode width.
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- i_valid  in  1  operand request valid.
- o_ready  out  1  ALU can accept a request this cycle.
- i_a, i_b  in  WIDTH  operands, unsigned unless stated otherwise.
- i_opcode  in  OP_WIDTH  operation.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  WIDTH  result.
- o_zero  out  1  result == 0.
- o_cf  out  1  carry, borrow or overflow flag; see Operation.
- o_of  out  1  signed overflow.

## Operation
- FSM states: IDLE, EXEC, DONE. Reset sends the FSM to IDLE.
- Request is accepted on an edge where i_valid && o_ready. Operands and opcode are latched at that edge.
- o_ready = i_rst_n && (state==IDLE || (state==DONE && i_ready)).
  - This is a combinational path from i_ready to o_ready, which allows back-to-back issue.
- Single-cycle ops go directly to DONE with the result registered at the accept edge:
  - SUM: a+b. cf = carry out; of = signed overflow.
  - SUB: a−b. cf = (a<b) unsigned borrow; of = signed overflow.
  - AND, OR, XOR: cf=0, of=0.
  - SHL, SHR (logical): shift amount = i_b[$clog2(WIDTH)-1:0]; upper bits of i_b are ignored. cf=0, of=0.
- MUL (iterative shift-add):
  - Accept moves the FSM to EXEC, loads a 2·WIDTH accumulator, and sets a step counter to WIDTH−1.
  - One step per EXEC cycle. On the final step the FSM moves to DONE.
  - result = low WIDTH bits of the product; cf = (high half ≠ 0); of=0.
- Unknown opcode: result 0, zero=1, cf=0, of=0, single-cycle.
- o_zero is derived from the registered o_result.
- In DONE, o_result and flags stay stable until the edge where i_ready=1. At that edge:
  - with a new accept: go to DONE or EXEC per the new op;
  - otherwise: go to IDLE with o_valid=0.
- i_valid and operands are ignored whenever o_ready=0.

## Timing
- Latency is counted from the accept edge to the first cycle o_valid=1.
  - Single-cycle ops: 1.
  - MUL (and DIV/REM when enabled): WIDTH.
- Throughput: single-cycle ops sustain 1 result per cycle with i_ready held high.
- Reset values: o_valid=0; o_result=0; o_cf=0; o_of=0; o_zero=1 (derived from o_result=0); o_ready=0 while i_rst_n=0.
- Reset asserted mid-EXEC or mid-DONE aborts the operation:
  - the in-flight result is discarded;
  - the first cycle after reset is IDLE with o_ready=1.
- Counter wrap: the step counter is $clog2(WIDTH) bits wide and is never decremented below 0.

## Configuration
- ALU_DIV_EN defined: adds OP_DIV (quotient) and OP_REM (remainder), computed by unsigned restoring division.
  - One quotient bit per EXEC cycle; latency WIDTH; cf=0, of=0.
  - Divide by zero completes single-cycle with cf=1:
    - DIV: result = all ones.
    - REM: result = i_a.
- ALU_DIV_EN undefined: OP_DIV and OP_REM behave as unknown opcodes. No divider logic is synthesised.

## Structure
- specs.vh (shared) holds:
  - existing OP_SUM, OP_SUB, OP_AND, OP_XOR;
  - new OP_OR, OP_SHL, OP_SHR, OP_MUL, OP_DIV, OP_REM;
  - the FSM state encodings.
- Sub-module alu_iter holds the sequential datapath:
  - accumulator/remainder register, step counter, one shift-add or restore step per cycle;
  - a done strobe to alu_mc.
- alu_mc owns:
  - the handshake and FSM;
  - single-cycle ops;
  - result and flag registers.

## Test plan
All scenarios use WIDTH=8.
- SUM 0xFF+0x01 → result 0x00, zero=1, cf=1, of=0, o_valid one cycle after accept.
- SUB 0x80−0x01 → 0x7F, cf=0, of=1. SUB 0x01−0x02 → 0xFF, cf=1, of=0.
- MUL 0x10×0x11 → 0x10, cf=1, o_valid exactly 8 cycles after accept, o_ready=0 during EXEC. MUL 0x0F×0x0F → 0xE1, cf=0.
- Backpressure and streaming:
  - DONE with i_ready=0 for 3 cycles → result stable, o_ready=0, concurrent i_valid not accepted.
  - Then 4 back-to-back XORs with i_ready=1 → 4 consecutive valid results in order.
- Reset at the 4th EXEC cycle of a MUL → o_valid=0 and o_ready=0 during reset, IDLE after. Next SHL 0x81 by 1 → 0x02.
- With ALU_DIV_EN:
  - DIV 0x64/0x07 → 0x0E; REM → 0x02; latency 8.
  - DIV 0x05/0x00 → 0xFF, cf=1, latency 1.
- Without ALU_DIV_EN: OP_DIV → result 0, zero=1, latency 1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encodings and flag helpers for the multi-cycle ALU.
package alu_mc_pkg;

  localparam int unsigned DEF_WORD     = 32;
  localparam int unsigned DEF_OP_WIDTH = 4;

  localparam int unsigned OP_SUM = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_XOR = 3;
  localparam int unsigned OP_OR  = 4;
  localparam int unsigned OP_SHL = 5;
  localparam int unsigned OP_SHR = 6;
  localparam int unsigned OP_MUL = 7;
  localparam int unsigned OP_DIV = 8;
  localparam int unsigned OP_REM = 9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Two's-complement overflow: effective operand signs agree but the result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic sub);
    return (a_msb == (b_msb ^ sub)) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the register-read stage and alu_mc.
interface alu_mc_if #(
  parameter int unsigned WIDTH    = alu_mc_pkg::DEF_WORD,
  parameter int unsigned OP_WIDTH = alu_mc_pkg::DEF_OP_WIDTH
);

  logic                i_valid;
  logic                o_ready;
  logic [WIDTH-1:0]    i_a;
  logic [WIDTH-1:0]    i_b;
  logic [OP_WIDTH-1:0] i_opcode;
  logic                o_valid;
  logic                i_ready;
  logic [WIDTH-1:0]    o_result;
  logic                o_zero;
  logic                o_cf;
  logic                o_of;

  modport master (
    output i_valid, i_a, i_b, i_opcode, i_ready,
    input  o_ready, o_valid, o_result, o_zero, o_cf, o_of
  );

  modport slave (
    input  i_valid, i_a, i_b, i_opcode, i_ready,
    output o_ready, o_valid, o_result, o_zero, o_cf, o_of
  );

endinterface

// File: rtl/alu_mc_iter.sv
// Iterative shift-add multiplier (and restoring divider when ALU_DIV_EN is defined).
module alu_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WORD
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
`ifdef ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] src, step_acc;
  logic [WIDTH-1:0]   opb;
`ifdef ALU_DIV_EN
  logic               div_q, div_d;
`endif

  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : '0)};
    return {s, acc[WIDTH-1:1]};
  endfunction

`ifdef ALU_DIV_EN
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0]   sh;
    logic             ge;
    logic [WIDTH-1:0] r;
    sh = acc[2*WIDTH-1:WIDTH-1];
    ge = (sh >= {1'b0, d});
    r  = ge ? WIDTH'(sh - {1'b0, d}) : sh[WIDTH-1:0];
    return {r, acc[WIDTH-2:0], ge};
  endfunction
`endif

  // The first step is folded into the load, so EXEC needs only WIDTH-1 cycles.
  always_comb begin
    src = start_i ? {{WIDTH{1'b0}}, a_i} : acc_q;
    opb = start_i ? b_i : opb_q;
`ifdef ALU_DIV_EN
    step_acc = (start_i ? div_i : div_q) ? div_step(src, opb) : mul_step(src, opb);
`else
    step_acc = mul_step(src, opb);
`endif
  end

  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
`ifdef ALU_DIV_EN
    div_d  = div_q;
`endif
    if (start_i) begin
      acc_d  = step_acc;
      opb_d  = b_i;
      cnt_d  = CW'(WIDTH - 1);
      busy_d = 1'b1;
`ifdef ALU_DIV_EN
      div_d  = div_i;
`endif
    end else if (busy_q) begin
      acc_d = step_acc;
      if (cnt_q == CW'(1)) busy_d = 1'b0;
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
`ifdef ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(1));
  assign lo_o   = step_acc[WIDTH-1:0];
  assign hi_o   = step_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake, FSM, single-cycle ops and result registers.
// Optional divide/remainder enabled by defining ALU_DIV_EN.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WORD,
  parameter int unsigned OP_WIDTH = DEF_OP_WIDTH
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  alu_mc_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [OP_WIDTH-1:0] C_SUM = OP_WIDTH'(OP_SUM);
  localparam logic [OP_WIDTH-1:0] C_SUB = OP_WIDTH'(OP_SUB);
  localparam logic [OP_WIDTH-1:0] C_AND = OP_WIDTH'(OP_AND);
  localparam logic [OP_WIDTH-1:0] C_XOR = OP_WIDTH'(OP_XOR);
  localparam logic [OP_WIDTH-1:0] C_OR  = OP_WIDTH'(OP_OR);
  localparam logic [OP_WIDTH-1:0] C_SHL = OP_WIDTH'(OP_SHL);
  localparam logic [OP_WIDTH-1:0] C_SHR = OP_WIDTH'(OP_SHR);
  localparam logic [OP_WIDTH-1:0] C_MUL = OP_WIDTH'(OP_MUL);
`ifdef ALU_DIV_EN
  localparam logic [OP_WIDTH-1:0] C_DIV = OP_WIDTH'(OP_DIV);
  localparam logic [OP_WIDTH-1:0] C_REM = OP_WIDTH'(OP_REM);
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cf_q, cf_d, of_q, of_d;
  logic             ready, accept, iter_start, iter_done;
  logic [WIDTH-1:0] sc_result;
  logic             sc_cf, sc_of, sc_iter;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] iter_lo, iter_hi;
`ifdef ALU_DIV_EN
  logic             div_q, div_d, rem_q, rem_d;
`endif

  always_comb begin
    sum_w     = {1'b0, bus.i_a} + {1'b0, bus.i_b};
    diff_w    = bus.i_a - bus.i_b;
    shamt     = bus.i_b[SHW-1:0];
    sc_result = '0;
    sc_cf     = 1'b0;
    sc_of     = 1'b0;
    sc_iter   = 1'b0;
    case (bus.i_opcode)
      C_SUM: begin
        sc_result = sum_w[WIDTH-1:0];
        sc_cf     = sum_w[WIDTH];
        sc_of     = signed_ovf(bus.i_a[WIDTH-1], bus.i_b[WIDTH-1], sum_w[WIDTH-1], 1'b0);
      end
      C_SUB: begin
        sc_result = diff_w;
        sc_cf     = bus.i_a < bus.i_b;
        sc_of     = signed_ovf(bus.i_a[WIDTH-1], bus.i_b[WIDTH-1], diff_w[WIDTH-1], 1'b1);
      end
      C_AND: sc_result = bus.i_a & bus.i_b;
      C_OR:  sc_result = bus.i_a | bus.i_b;
      C_XOR: sc_result = bus.i_a ^ bus.i_b;
      C_SHL: sc_result = bus.i_a << shamt;
      C_SHR: sc_result = bus.i_a >> shamt;
      C_MUL: sc_iter   = 1'b1;
`ifdef ALU_DIV_EN
      // Divide by zero never enters the iterative unit.
      C_DIV: begin
        if (bus.i_b == '0) begin
          sc_result = '1;
          sc_cf     = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
      C_REM: begin
        if (bus.i_b == '0) begin
          sc_result = bus.i_a;
          sc_cf     = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign ready      = i_rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.i_ready));
  assign accept     = bus.i_valid && ready;
  assign iter_start = accept && sc_iter;

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .start_i (iter_start),
`ifdef ALU_DIV_EN
    .div_i   ((bus.i_opcode == C_DIV) || (bus.i_opcode == C_REM)),
`endif
    .a_i     (bus.i_a),
    .b_i     (bus.i_b),
    .done_o  (iter_done),
    .lo_o    (iter_lo),
    .hi_o    (iter_hi)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cf_d     = cf_q;
    of_d     = of_q;
`ifdef ALU_DIV_EN
    div_d    = div_q;
    rem_d    = rem_q;
`endif
    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        if (iter_done) begin
          state_d  = S_DONE;
          result_d = iter_lo;
          cf_d     = |iter_hi;
          of_d     = 1'b0;
`ifdef ALU_DIV_EN
          if (div_q) cf_d = 1'b0;
          if (rem_q) result_d = iter_hi;
`endif
        end
      end
      S_DONE: if (bus.i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Accept is only possible from IDLE or a consumed DONE, so it overrides the above.
    if (accept) begin
`ifdef ALU_DIV_EN
      div_d = (bus.i_opcode == C_DIV) || (bus.i_opcode == C_REM);
      rem_d = (bus.i_opcode == C_REM);
`endif
      if (sc_iter) begin
        state_d = S_EXEC;
      end else begin
        state_d  = S_DONE;
        result_d = sc_result;
        cf_d     = sc_cf;
        of_d     = sc_of;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
`ifdef ALU_DIV_EN
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
`ifdef ALU_DIV_EN
      div_q    <= div_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid  = (state_q == S_DONE);
  assign bus.o_result = result_q;
  assign bus.o_zero   = (result_q == '0);
  assign bus.o_cf     = cf_q;
  assign bus.o_of     = of_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=8; ALU_DIV_EN selects the divider checks.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  alu_mc_if #(.WIDTH(8), .OP_WIDTH(4)) bus ();
  alu_mc #(.WIDTH(8), .OP_WIDTH(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // {o_valid, o_result, o_zero, o_cf, o_of}
  function automatic logic [11:0] obs();
    return {bus.o_valid, bus.o_result, bus.o_zero, bus.o_cf, bus.o_of};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.i_opcode = op;
    bus.i_a      = a;
    bus.i_b      = b;
    bus.i_valid  = 1'b1;
    @(posedge clk); #1;
    bus.i_valid  = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_a = '0; bus.i_b = '0; bus.i_opcode = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = obs();
    checks++;
    if (got !== 12'b0_00000000_1_0_0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", got, 12'b0_00000000_1_0_0);
    end
    checks++;
    if (bus.o_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0", bus.o_ready);
    end
    rst_n = 1'b1; bus.i_ready = 1'b0; #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.o_ready);
    end
  endtask

  task automatic test_sum();
    int lat; logic [11:0] got;
    issue(4'(OP_SUM), 8'hFF, 8'h01);
    wait_result(lat);
    got = obs();
    checks++;
    if (lat != 1) begin failures++; $display("FAIL sum_latency got=%0d exp=1", lat); end
    checks++;
    if (got !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sum_ff_01 got=%h exp=%h", got, {1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
    end
    consume();
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL sum_consumed got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_sub();
    int lat; logic [11:0] got;
    issue(4'(OP_SUB), 8'h80, 8'h01);
    wait_result(lat);
    got = obs();
    checks++;
    if (got !== {1'b1, 8'h7F, 1'b0, 1'b0, 1'b1} || lat != 1) begin
      failures++; $display("FAIL sub_80_01 got=%h lat=%0d exp=%h lat=1", got, lat, {1'b1, 8'h7F, 1'b0, 1'b0, 1'b1});
    end
    consume();
    issue(4'(OP_SUB), 8'h01, 8'h02);
    wait_result(lat);
    got = obs();
    checks++;
    if (got !== {1'b1, 8'hFF, 1'b0, 1'b1, 1'b0} || lat != 1) begin
      failures++; $display("FAIL sub_01_02 got=%h lat=%0d exp=%h lat=1", got, lat, {1'b1, 8'hFF, 1'b0, 1'b1, 1'b0});
    end
    consume();
  endtask

  task automatic test_mul();
    int lat; int ready_bad; logic [11:0] got;
    bus.i_ready = 1'b1;
    issue(4'(OP_MUL), 8'h10, 8'h11);
    lat = 1; ready_bad = 0;
    while (!bus.o_valid && lat < 40) begin
      if (bus.o_ready !== 1'b0) ready_bad++;
      @(posedge clk); #1;
      lat++;
    end
    got = obs();
    checks++;
    if (lat != 8) begin failures++; $display("FAIL mul_latency got=%0d exp=8", lat); end
    checks++;
    if (ready_bad != 0) begin failures++; $display("FAIL mul_exec_ready got=%0d_cycles_high exp=0", ready_bad); end
    checks++;
    if (got !== {1'b1, 8'h10, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL mul_10_11 got=%h exp=%h", got, {1'b1, 8'h10, 1'b0, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mul_auto_consume got=%b exp=0", bus.o_valid); end
    issue(4'(OP_MUL), 8'h0F, 8'h0F);
    wait_result(lat);
    got = obs();
    checks++;
    if (got !== {1'b1, 8'hE1, 1'b0, 1'b0, 1'b0} || lat != 8) begin
      failures++; $display("FAIL mul_0f_0f got=%h lat=%0d exp=%h lat=8", got, lat, {1'b1, 8'hE1, 1'b0, 1'b0, 1'b0});
    end
    consume();
    issue(4'(OP_MUL), 8'hFF, 8'hFF);
    wait_result(lat);
    got = obs();
    checks++;
    if (got !== {1'b1, 8'h01, 1'b0, 1'b1, 1'b0} || lat != 8) begin
      failures++; $display("FAIL mul_ff_ff got=%h lat=%0d exp=%h lat=8", got, lat, {1'b1, 8'h01, 1'b0, 1'b1, 1'b0});
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(4'(OP_AND), 8'hF0, 8'h3C);
    wait_result(lat);
    bus.i_opcode = 4'(OP_SUM); bus.i_a = 8'h01; bus.i_b = 8'h01; bus.i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== 8'h30 || bus.o_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d got=v%b r%h rdy%b exp=v1 r30 rdy0", k, bus.o_valid, bus.o_result, bus.o_ready);
      end
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_result !== 8'h30) begin
      failures++; $display("FAIL stall_after got=v%b r%h exp=v1 r30", bus.o_valid, bus.o_result);
    end
    consume();
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL stall_no_accept got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4] = '{8'hAA, 8'h0F, 8'h12, 8'h5A};
    logic [7:0] vb [4] = '{8'h55, 8'hFF, 8'h34, 8'h5A};
    logic [7:0] ve [4] = '{8'hFF, 8'hF0, 8'h26, 8'h00};
    bus.i_ready = 1'b1;
    bus.i_opcode = 4'(OP_XOR);
    for (int k = 0; k < 4; k++) begin
      bus.i_a = va[k]; bus.i_b = vb[k]; bus.i_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== ve[k] || bus.o_zero !== (ve[k] == 8'h00)) begin
        failures++;
        $display("FAIL b2b_xor_%0d got=v%b r%h z%b exp=v1 r%h", k, bus.o_valid, bus.o_result, bus.o_zero, ve[k]);
      end
    end
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_reset_mid_exec();
    int lat; int seen; logic [11:0] got;
    issue(4'(OP_MUL), 8'h03, 8'h05);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; #1;
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) begin
      failures++; $display("FAIL abort_during got=rdy%b v%b exp=rdy0 v0", bus.o_ready, bus.o_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) begin
      failures++; $display("FAIL abort_in_reset got=rdy%b v%b exp=rdy0 v0", bus.o_ready, bus.o_valid);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL abort_idle_ready got=%b exp=1", bus.o_ready); end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.o_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_discard got=%0d_valid_cycles exp=0", seen); end
    issue(4'(OP_SHL), 8'h81, 8'h01);
    wait_result(lat);
    got = obs();
    checks++;
    if (got !== {1'b1, 8'h02, 1'b0, 1'b0, 1'b0} || lat != 1) begin
      failures++; $display("FAIL shl_81_1 got=%h lat=%0d exp=%h lat=1", got, lat, {1'b1, 8'h02, 1'b0, 1'b0, 1'b0});
    end
    consume();
    issue(4'(OP_SHR), 8'h81, 8'h0B);
    wait_result(lat);
    got = obs();
    checks++;
    if (got !== {1'b1, 8'h10, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL shr_81_0b got=%h exp=%h", got, {1'b1, 8'h10, 1'b0, 1'b0, 1'b0});
    end
    consume();
  endtask

  task automatic test_unknown_op();
    int lat; logic [11:0] got;
    issue(4'hF, 8'h55, 8'h0A);
    wait_result(lat);
    got = obs();
    checks++;
    if (got !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0} || lat != 1) begin
      failures++; $display("FAIL unknown_op got=%h lat=%0d exp=%h lat=1", got, lat, {1'b1, 8'h00, 1'b1, 1'b0, 1'b0});
    end
    consume();
  endtask

  task automatic test_div();
    int lat; logic [11:0] got;
`ifdef ALU_DIV_EN
    logic [3:0]  op [4] = '{4'(OP_DIV), 4'(OP_REM), 4'(OP_DIV), 4'(OP_REM)};
    logic [7:0]  va [4] = '{8'h64, 8'h64, 8'h05, 8'h05};
    logic [7:0]  vb [4] = '{8'h07, 8'h07, 8'h00, 8'h00};
    logic [11:0] ve [4] = '{{1'b1, 8'h0E, 1'b0, 1'b0, 1'b0}, {1'b1, 8'h02, 1'b0, 1'b0, 1'b0},
                            {1'b1, 8'hFF, 1'b0, 1'b1, 1'b0}, {1'b1, 8'h05, 1'b0, 1'b1, 1'b0}};
    int          vl [4] = '{8, 8, 1, 1};
`else
    logic [3:0]  op [2] = '{4'(OP_DIV), 4'(OP_REM)};
    logic [7:0]  va [2] = '{8'h64, 8'h64};
    logic [7:0]  vb [2] = '{8'h07, 8'h07};
    logic [11:0] ve [2] = '{{1'b1, 8'h00, 1'b1, 1'b0, 1'b0}, {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}};
    int          vl [2] = '{1, 1};
`endif
    for (int k = 0; k < $size(op); k++) begin
      issue(op[k], va[k], vb[k]);
      wait_result(lat);
      got = obs();
      checks++;
      if (got !== ve[k] || lat != vl[k]) begin
        failures++; $display("FAIL divrem_%0d got=%h lat=%0d exp=%h lat=%0d", k, got, lat, ve[k], vl[k]);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_sub();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    test_unknown_op();
    test_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
